// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed 7-segment digit scanner.
package scan_pkg;

  localparam int DIGITS_MIN = 2;
  localparam int DIGITS_MAX = 8;
  localparam int DEAD_MIN   = 0;
  localparam int DEAD_MAX   = 3;

  localparam int unsigned EN_W = 8;

  // One-hot digit enable at the requested polarity; all-inactive when !active.
  function automatic logic [EN_W-1:0] en_word(input logic [2:0] idx,
                                              input logic       active,
                                              input logic       polarity);
    logic [EN_W-1:0] w;
    w = active ? (EN_W'(1) << idx) : '0;
    return polarity ? w : ~w;
  endfunction

endpackage

// File: rtl/scan_lzb.sv
// Leading-zero blanking: marks digits that are zero, carry no dp, and have
// only zero/no-dp digits above them. Digit 0 always stays lit.
module scan_lzb #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] digits_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic                lzb_en_i,
  output logic [DIGITS-1:0]   dark_o
);

  logic run;

  // Walk from the MS digit down, keeping a running "still leading" flag.
  always_comb begin
    dark_o = '0;
    run    = lzb_en_i;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run       = run & (digits_i[4*i +: 4] == 4'd0) & ~dp_i[i];
      dark_o[i] = run;
    end
  end

endmodule

// File: rtl/scan_mux_n.sv
// Time-multiplexed N-digit scanner with per-frame snapshot, leading-zero
// blanking, blank mask, dp pass-through and optional inter-digit dead time.
module scan_mux_n
  import scan_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DEAD_CYCLES    = 0,
  parameter int EN_ACTIVE_HIGH = 1
) (
  input  logic                clk_1kHz,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] datain,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic                lzb_en,
  output logic [3:0]          scan_data,
  output logic                scan_dp,
  output logic [DIGITS-1:0]   scan_en,
  output logic                frame_start
);

  localparam int unsigned IW        = $clog2(DIGITS);
  localparam logic [IW-1:0] MS_IDX  = IW'(DIGITS - 1);
  localparam logic [1:0]    DEAD_LAST = 2'(DEAD_CYCLES);
  localparam logic          POL     = (EN_ACTIVE_HIGH != 0);

  // Reject illegal parameterisations at elaboration.
  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX ||
      DEAD_CYCLES < DEAD_MIN || DEAD_CYCLES > DEAD_MAX) begin : g_bad_param
    $error("scan_mux_n: DIGITS or DEAD_CYCLES out of range");
  end

  // Position registers describe the slot the next edge will enter.
  logic [IW-1:0]       dig_q, dig_d;
  logic [1:0]          dcnt_q, dcnt_d;

  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_bm_q, sh_bm_d;
  logic                sh_lz_q, sh_lz_d;

  logic [3:0]          data_q, data_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                fs_q, fs_d;

  logic [DIGITS-1:0]   live_dark, shadow_dark;

  logic                ms_slot;
  logic                dark;
  logic [3:0]          nib;
  logic                nib_dp;
  logic [EN_W-1:0]     en_on, en_off;

  scan_lzb #(.DIGITS(DIGITS)) u_lzb_live (
    .digits_i (datain),
    .dp_i     (dp_in),
    .lzb_en_i (lzb_en),
    .dark_o   (live_dark)
  );

  scan_lzb #(.DIGITS(DIGITS)) u_lzb_shadow (
    .digits_i (sh_data_q),
    .dp_i     (sh_dp_q),
    .lzb_en_i (sh_lz_q),
    .dark_o   (shadow_dark)
  );

  // Next slot position, snapshot capture and output values for the entered slot.
  always_comb begin
    dig_d     = dig_q;
    dcnt_d    = dcnt_q;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_bm_d   = sh_bm_q;
    sh_lz_d   = sh_lz_q;
    en_on     = en_word(3'(dig_q), 1'b1, POL);
    en_off    = en_word(3'(dig_q), 1'b0, POL);
    data_d    = 4'd0;
    dp_d      = 1'b0;
    en_d      = en_off[DIGITS-1:0];
    fs_d      = 1'b0;
    ms_slot   = (dcnt_q == 2'd0) && (dig_q == MS_IDX);
    dark      = 1'b1;
    nib       = 4'd0;
    nib_dp    = 1'b0;

    if (dcnt_q == DEAD_LAST) begin
      dcnt_d = 2'd0;
      dig_d  = (dig_q == '0) ? MS_IDX : dig_q - IW'(1);
    end else begin
      dcnt_d = dcnt_q + 2'd1;
    end

    if (ms_slot) begin
      // MS slot shows the live inputs and freezes them for the rest of the frame.
      sh_data_d = datain;
      sh_dp_d   = dp_in;
      sh_bm_d   = blank_mask;
      sh_lz_d   = lzb_en;
      nib       = datain[{dig_q, 2'b00} +: 4];
      nib_dp    = dp_in[dig_q];
      dark      = blank_mask[dig_q] | live_dark[dig_q];
      fs_d      = 1'b1;
    end else if (dcnt_q == 2'd0) begin
      nib       = sh_data_q[{dig_q, 2'b00} +: 4];
      nib_dp    = sh_dp_q[dig_q];
      dark      = sh_bm_q[dig_q] | shadow_dark[dig_q];
    end

    if (!dark) begin
      data_d = nib;
      dp_d   = nib_dp;
      en_d   = en_on[DIGITS-1:0];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_1kHz) begin
    if (!reset) begin
      dig_q     <= MS_IDX;
      dcnt_q    <= 2'd0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_bm_q   <= '0;
      sh_lz_q   <= 1'b0;
      data_q    <= 4'd0;
      dp_q      <= 1'b0;
      en_q      <= en_off[DIGITS-1:0];
      fs_q      <= 1'b0;
    end else begin
      dig_q     <= dig_d;
      dcnt_q    <= dcnt_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_bm_q   <= sh_bm_d;
      sh_lz_q   <= sh_lz_d;
      data_q    <= data_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
      fs_q      <= fs_d;
    end
  end

  assign scan_data   = data_q;
  assign scan_dp     = dp_q;
  assign scan_en     = en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Bench for scan_mux_n: three configurations driven side by side and checked
// against a frame-position reference model.
module tb_scan_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] din [3];
  logic [7:0]  dpv [3];
  logic [7:0]  bmv [3];
  logic        lzv [3];

  logic [15:0] din0, din1;
  logic [31:0] din2;
  logic [3:0]  dp0, dp1, bm0, bm1;
  logic [7:0]  dp2, bm2;
  assign din0 = din[0][15:0];
  assign din1 = din[1][15:0];
  assign din2 = din[2];
  assign dp0  = dpv[0][3:0];
  assign dp1  = dpv[1][3:0];
  assign dp2  = dpv[2];
  assign bm0  = bmv[0][3:0];
  assign bm1  = bmv[1][3:0];
  assign bm2  = bmv[2];

  logic [3:0] sd0, sd1, sd2;
  logic       sp0, sp1, sp2;
  logic [3:0] en0, en1;
  logic [7:0] en2;
  logic       fs0, fs1, fs2;

  scan_mux_n #(.DIGITS(4), .DEAD_CYCLES(0), .EN_ACTIVE_HIGH(1)) u_dut0 (
    .clk_1kHz(clk), .reset(rst_n), .datain(din0), .dp_in(dp0), .blank_mask(bm0),
    .lzb_en(lzv[0]), .scan_data(sd0), .scan_dp(sp0), .scan_en(en0), .frame_start(fs0));

  scan_mux_n #(.DIGITS(4), .DEAD_CYCLES(1), .EN_ACTIVE_HIGH(0)) u_dut1 (
    .clk_1kHz(clk), .reset(rst_n), .datain(din1), .dp_in(dp1), .blank_mask(bm1),
    .lzb_en(lzv[1]), .scan_data(sd1), .scan_dp(sp1), .scan_en(en1), .frame_start(fs1));

  scan_mux_n #(.DIGITS(8), .DEAD_CYCLES(0), .EN_ACTIVE_HIGH(1)) u_dut2 (
    .clk_1kHz(clk), .reset(rst_n), .datain(din2), .dp_in(dp2), .blank_mask(bm2),
    .lzb_en(lzv[2]), .scan_data(sd2), .scan_dp(sp2), .scan_en(en2), .frame_start(fs2));

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Reference model state: position in frame plus frozen frame inputs.
  int          pos [3];
  logic [31:0] sdat [3];
  logic [7:0]  sdp [3];
  logic [7:0]  sbm [3];
  logic        slz [3];
  logic [7:0]  xen [3];
  logic [3:0]  xdata [3];
  logic        xdp [3];
  logic        xfs [3];

  function automatic int ndig(int k);
    return (k == 2) ? 8 : 4;
  endfunction
  function automatic int ndead(int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic logic pol(int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [3:0] nibble(logic [31:0] v, int d);
    logic [31:0] t;
    t = v >> (4 * d);
    return t[3:0];
  endfunction

  // A digit is dark if masked, or if it and everything above it is a
  // dp-less zero while blanking is on (digit 0 excepted).
  function automatic logic is_dark(int k, int d);
    if (sbm[k][d]) return 1'b1;
    if (!slz[k] || d == 0) return 1'b0;
    for (int j = d; j < ndig(k); j++)
      if (nibble(sdat[k], j) != 4'd0 || sdp[k][j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(int k);
    int nd, dead, len, d;
    logic [7:0] inact, onehot;
    nd    = ndig(k);
    dead  = ndead(k);
    len   = nd * (1 + dead);
    inact = pol(k) ? 8'h00 : 8'((32'h1 << nd) - 1);
    xen[k] = inact; xdata[k] = 4'd0; xdp[k] = 1'b0; xfs[k] = 1'b0;
    if (!rst_n) begin
      pos[k] = -1; sdat[k] = '0; sdp[k] = '0; sbm[k] = '0; slz[k] = 1'b0;
      return;
    end
    pos[k] = (pos[k] + 1) % len;
    if (pos[k] == 0) begin
      sdat[k] = din[k]; sdp[k] = dpv[k]; sbm[k] = bmv[k]; slz[k] = lzv[k];
      xfs[k] = 1'b1;
    end
    if (pos[k] % (1 + dead) == 0) begin
      d = nd - 1 - pos[k] / (1 + dead);
      if (!is_dark(k, d)) begin
        xdata[k] = nibble(sdat[k], d);
        xdp[k]   = sdp[k][d];
        onehot   = 8'h1 << d;
        xen[k]   = pol(k) ? onehot : (inact & ~onehot);
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge: advance the model, then compare all three DUTs.
  task automatic step();
    logic [7:0] oen [3];
    logic [3:0] odat [3];
    logic       odp [3];
    logic       ofs [3];
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    cyc++;
    oen[0] = {4'b0, en0}; odat[0] = sd0; odp[0] = sp0; ofs[0] = fs0;
    oen[1] = {4'b0, en1}; odat[1] = sd1; odp[1] = sp1; ofs[1] = fs1;
    oen[2] = en2;         odat[2] = sd2; odp[2] = sp2; ofs[2] = fs2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d_scan_en", k),      32'(oen[k]),  32'(xen[k]));
      chk($sformatf("dut%0d_scan_data", k),    32'(odat[k]), 32'(xdata[k]));
      chk($sformatf("dut%0d_scan_dp", k),      32'(odp[k]),  32'(xdp[k]));
      chk($sformatf("dut%0d_frame_start", k),  32'(ofs[k]),  32'(xfs[k]));
    end
  endtask

  function automatic logic [31:0] rand_digits();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if ($urandom_range(0, 2) == 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  logic [3:0] plan_en0 [4];
  logic [3:0] plan_en1 [8];

  initial begin
    plan_en0 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    plan_en1 = '{4'b0111, 4'b1111, 4'b1011, 4'b1111, 4'b1101, 4'b1111, 4'b1110, 4'b1111};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0; dpv[k] = '0; bmv[k] = '0; lzv[k] = 1'b0; pos[k] = -1;
    end
    repeat (3) step();

    // Basic scan of 1234 / 12345 with plain constant cross-checks.
    din[0] = 32'h1234; din[1] = 32'h1234; din[2] = 32'h0001_2345; lzv[2] = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("plan_dut0_en",   32'(en0), 32'(plan_en0[i % 4]));
      chk("plan_dut0_data", 32'(sd0), 32'(i % 4 + 1));
      chk("plan_dut1_en",   32'(en1), 32'(plan_en1[i % 8]));
    end

    // Leading-zero blanking patterns.
    din[0] = 32'h0047; lzv[0] = 1'b1;
    repeat (8) step();
    din[0] = 32'h0000;
    repeat (8) step();
    din[0] = 32'h0007; dpv[0] = 8'b0100;
    repeat (8) step();

    // Snapshot: change inputs during the digit-2 slot.
    din[0] = 32'h1234; dpv[0] = '0; lzv[0] = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8 && pos[0] != 1; i++) step();
    din[0] = 32'h5678;
    repeat (8) step();

    // Blank mask on the dead-time, active-low instance.
    bmv[1] = 8'b0010;
    repeat (16) step();

    // Reset during the digit-1 slot, then release.
    for (int i = 0; i < 8 && pos[0] != 2; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();

    // Randomised inputs changing at arbitrary phases, with occasional resets.
    repeat (600) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          din[k] = rand_digits();
          dpv[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
          bmv[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
          lzv[k] = 1'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/scan_mux_n.md
# scan_mux_n

Parametrised, time-multiplexed 7-segment digit scanner for an N-digit common-anode or common-cathode display, clocked by the 1 kHz scan clock. It sits between the BCD value producers (counters, score logic) and the BCD-to-segment decoder. It adds four features: a per-frame input snapshot, leading-zero blanking, a per-digit blank mask with decimal-point pass-through, and configurable dead-time between digits against ghosting.

## Interface
Parameters:
- DIGITS, 4: number of digits, legal range 2..8.
- DEAD_CYCLES, 0: all-off cycles inserted after each digit slot, legal range 0..3.
- EN_ACTIVE_HIGH, 1: digit-enable polarity. 1 means enable is active-high; 0 means active-low.

Ports:
- clk_1kHz  in  1  scan clock; the only clock in the block.
- reset  in  1  reset is synchronous and active-low.
- datain  in  4*DIGITS  BCD digits; [4*DIGITS-1 -: 4] is the most significant digit.
- dp_in  in  DIGITS  decimal point per digit; bit i belongs to digit i.
- blank_mask  in  DIGITS  1 forces digit i dark.
- lzb_en  in  1  enables leading-zero blanking.
- scan_data  out  4  BCD code of the digit currently shown.
- scan_dp  out  1  decimal point of the digit currently shown.
- scan_en  out  DIGITS  one-hot digit select at the polarity set by EN_ACTIVE_HIGH; bit DIGITS-1 is the MS digit.
- frame_start  out  1  one-cycle pulse marking the MS-digit slot.

## Operation
- Phase counter walks slots in this order: MS digit (DIGITS-1) first, down to digit 0.
  - Each digit slot lasts 1 cycle and is followed by DEAD_CYCLES dead cycles.
  - Frame length is DIGITS*(1+DEAD_CYCLES) cycles.
  - After the last dead cycle of digit 0, the counter wraps to the MS digit.
- Snapshot: on the edge that displays the MS digit, datain, dp_in, blank_mask and lzb_en are latched into shadow registers.
  - The MS digit is displayed from the live inputs sampled on that same edge.
  - All remaining slots of the frame use the shadow values.
  - Input changes inside a frame therefore become visible only at the next frame.
- Leading-zero blanking, applied when lzb_en (as snapshotted) is 1:
  - Digit i (i>0) is blanked if it and every more-significant digit are 0, and none of those digits has dp set.
  - Digit 0 is never blanked by leading-zero blanking.
- Digit i is dark if blank_mask[i] is set or it is leading-zero blanked.
- Dark slot: scan_en all inactive, scan_data=0, scan_dp=0. The slot still occupies its time, so the refresh rate stays constant.
- Dead cycle: scan_en all inactive, scan_data=0, scan_dp=0, frame_start=0.
- BCD values 10..15 pass through unchanged and count as non-zero for blanking.
- "Inactive" means 0 when EN_ACTIVE_HIGH=1 and 1 when EN_ACTIVE_HIGH=0.

## Timing
- All outputs are registered and update on posedge clk_1kHz.
- Latency: the digit for a slot appears on the edge that enters that slot; there is no extra pipeline stage.
- Reset (reset=0 at an edge), effective on that edge regardless of phase, including mid-frame:
  - Phase goes to the MS slot.
  - Shadows clear to 0.
  - scan_data=0, scan_dp=0, scan_en all inactive, frame_start=0.
- First edge with reset=1: MS digit is shown, frame_start=1, snapshot taken.
- frame_start is high exactly one cycle per frame, coincident with the MS slot outputs.
- Blanking and dark decisions use the same values (live or shadow) as the displayed data for that slot.

## Structure
- Package scan_pkg holds:
  - localparams for the legal DIGITS and DEAD_CYCLES ranges.
  - function en_word(idx, active, polarity) returning the scan_en vector.
- Sub-module scan_lzb (combinational): takes a digit vector, dp vector and lzb_en, and returns a DIGITS-wide dark mask.
  - It is instantiated twice: once on the live inputs and once on the shadow registers. Alternatively, a muxed source feeds a single instance.
- Top level contains only the phase counter, dead-time counter, shadow registers and output registers.

## Test plan
- DIGITS=4, DEAD_CYCLES=0, active-high, datain=16'h1234, lzb_en=0.
  - Required: scan_en 1000/0100/0010/0001 with scan_data 1/2/3/4, repeating.
  - frame_start=1 only with 1000.
- lzb_en=1, datain=16'h0047: slots 3 and 2 dark (scan_en=0000, scan_data=0), then 4, then 7.
  - datain=0 → only digit0 shows 0.
  - datain=16'h0007 with dp_in=4'b0100 → digit2 shows 0 with scan_dp=1, digit3 dark.
- Snapshot: datain=16'h1234, changed to 16'h5678 during the digit-2 slot.
  - Required: the rest of the frame shows 3, 4.
  - Next frame shows 5, 6, 7, 8.
- DEAD_CYCLES=1, EN_ACTIVE_HIGH=0, datain=16'h1234.
  - Required: 0111, 1111, 1011, 1111, 1101, 1111, 1110, 1111; frame length 8 cycles.
  - blank_mask=4'b0010 → digit1 slot shows 1111.
- Reset asserted during the digit-1 slot.
  - Required: outputs go inactive on that edge.
  - After release: MS digit on the first edge with frame_start=1.
- DIGITS=8, datain=32'h00012345, lzb_en=1 → three dark slots, then 1..5; frame length 8.
